// File: rtl/mem_port_arbiter.sv
// Merges NCH sram-like master ports onto one sram-like slave port, tracking
// the owner of each accepted request in an in-order ID FIFO to route responses.
module mem_port_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned RR_MODE = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NCH-1:0]                 m_req,
    input  logic [NCH-1:0]                 m_wr,
    input  logic [2*NCH-1:0]               m_size,
    input  logic [NCH*(DW/8)-1:0]          m_wstrb,
    input  logic [NCH*AW-1:0]              m_addr,
    input  logic [NCH*DW-1:0]              m_wdata,
    output logic [NCH-1:0]                 m_addr_ok,
    output logic [NCH-1:0]                 m_data_ok,
    output logic [DW-1:0]                  m_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [DW/8-1:0]                s_wstrb,
    output logic [AW-1:0]                  s_addr,
    output logic [DW-1:0]                  s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [DW-1:0]                  s_rdata,
    output logic [$clog2(DEPTH):0]         outstanding,
    output logic                           err_spurious
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(NCH);

    logic [IW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          err_q, err_d;

    logic          fix_found, rr_found, gnt_v, not_full;
    logic [IW-1:0] fix_idx, rr_idx, gnt_idx, rr_cand, head;
    logic          push, pop;
    int            rr_sum;

    // Arbitration: fixed picks the highest requesting index, RR the first at/after rr_ptr.
    always_comb begin
        fix_found = 1'b0;
        fix_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_req[i]) begin
                fix_found = 1'b1;
                fix_idx   = IW'(i);
            end
        end
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = 0;
        rr_cand  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            rr_sum = int'(32'(rr_ptr_q)) + k;
            if (rr_sum >= int'(NCH)) rr_sum = rr_sum - int'(NCH);
            rr_cand = IW'(rr_sum);
            if (m_req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    assign not_full = (cnt_q != CW'(DEPTH));
    assign gnt_v    = not_full && ((RR_MODE != 0) ? rr_found : fix_found);
    assign gnt_idx  = (RR_MODE != 0) ? rr_idx : fix_idx;
    assign push     = gnt_v && s_addr_ok;
    assign pop      = s_data_ok && (cnt_q != '0);
    assign head     = fifo_q[rd_ptr_q];

    // Slave-side field mux and per-channel handshake fan-out.
    always_comb begin
        s_req     = gnt_v;
        s_wr      = 1'b0;
        s_size    = '0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        m_rdata   = pop ? s_rdata : '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_v && (gnt_idx == IW'(i))) begin
                s_wr         = m_wr[i];
                s_size       = m_size[2*i +: 2];
                s_wstrb      = m_wstrb[SW*i +: SW];
                s_addr       = m_addr[AW*i +: AW];
                s_wdata      = m_wdata[DW*i +: DW];
                m_addr_ok[i] = s_addr_ok;
            end
            if (pop && (head == IW'(i))) m_data_ok[i] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
        err_d = err_q || (s_data_ok && (cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            if (push) fifo_q[wr_ptr_q] <= gnt_idx;
        end
    end

    assign outstanding  = cnt_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share stimulus.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_req, m_wr;
    logic [3:0]  m_size;
    logic [7:0]  m_wstrb;
    logic [63:0] m_addr, m_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    logic [1:0]  addr_ok_f, data_ok_f, addr_ok_r, data_ok_r;
    logic [31:0] rdata_f, rdata_r, s_addr_f, s_addr_r, s_wdata_f, s_wdata_r;
    logic        s_req_f, s_req_r, s_wr_f, s_wr_r, err_f, err_r;
    logic [1:0]  s_size_f, s_size_r;
    logic [3:0]  s_wstrb_f, s_wstrb_r;
    logic [2:0]  out_f, out_r;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NCH(2), .AW(32), .DW(32), .DEPTH(4), .RR_MODE(0)) u_fix (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(addr_ok_f), .m_data_ok(data_ok_f), .m_rdata(rdata_f),
        .s_req(s_req_f), .s_wr(s_wr_f), .s_size(s_size_f), .s_wstrb(s_wstrb_f),
        .s_addr(s_addr_f), .s_wdata(s_wdata_f), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata), .outstanding(out_f),
        .err_spurious(err_f)
    );

    mem_port_arbiter #(.NCH(2), .AW(32), .DW(32), .DEPTH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(addr_ok_r), .m_data_ok(data_ok_r), .m_rdata(rdata_r),
        .s_req(s_req_r), .s_wr(s_wr_r), .s_size(s_size_r), .s_wstrb(s_wstrb_r),
        .s_addr(s_addr_r), .s_wdata(s_wdata_r), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata), .outstanding(out_r),
        .err_spurious(err_r)
    );

    typedef struct {
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] srd;
        logic        exp_sreq;
        logic [31:0] exp_saddr;
        logic        exp_swr;
        logic [1:0]  exp_aok;
        logic [1:0]  exp_dok;
        logic [31:0] exp_rd;
        logic [2:0]  exp_out;
    } vec_t;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    vec_t tbl[15];

    function automatic vec_t mk(input logic [1:0] req, input logic aok, input logic dok,
                                input logic [31:0] srd, input logic sreq,
                                input logic [31:0] saddr, input logic swr,
                                input logic [1:0] eaok, input logic [1:0] edok,
                                input logic [31:0] erd, input logic [2:0] eout);
        vec_t v;
        v.req = req; v.aok = aok; v.dok = dok; v.srd = srd;
        v.exp_sreq = sreq; v.exp_saddr = saddr; v.exp_swr = swr;
        v.exp_aok = eaok; v.exp_dok = edok; v.exp_rd = erd; v.exp_out = eout;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic aok, input logic dok,
                         input logic [31:0] srd);
        @(negedge clk);
        m_req = req; s_addr_ok = aok; s_data_ok = dok; s_rdata = srd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [1:0]  q[$];
    logic [1:0]  rq;
    logic        dk;
    logic [1:0]  ch;

    initial begin
        reset = 1'b1;
        m_req = '0; m_wr = 2'b10; m_size = {2'd2, 2'd0}; m_wstrb = {4'hF, 4'h1};
        m_addr = {A1, A0}; m_wdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

        // fixed priority: grant, response, concurrent accept+response, fill to full
        tbl[0]  = mk(2'b00, 0, 0, 32'h0,         0, 32'h0, 0, 2'b00, 2'b00, 32'h0,         3'd0);
        tbl[1]  = mk(2'b11, 1, 0, 32'h0,         1, A1,    1, 2'b10, 2'b00, 32'h0,         3'd0);
        tbl[2]  = mk(2'b00, 0, 1, 32'hDEADBEEF,  0, 32'h0, 0, 2'b00, 2'b10, 32'hDEADBEEF,  3'd1);
        tbl[3]  = mk(2'b01, 0, 0, 32'h0,         1, A0,    0, 2'b00, 2'b00, 32'h0,         3'd0);
        tbl[4]  = mk(2'b01, 1, 0, 32'h0,         1, A0,    0, 2'b01, 2'b00, 32'h0,         3'd0);
        tbl[5]  = mk(2'b10, 1, 1, 32'h1111_1111, 1, A1,    1, 2'b10, 2'b01, 32'h1111_1111, 3'd1);
        tbl[6]  = mk(2'b00, 0, 1, 32'h2222_2222, 0, 32'h0, 0, 2'b00, 2'b10, 32'h2222_2222, 3'd1);
        tbl[7]  = mk(2'b00, 0, 0, 32'h3333_3333, 0, 32'h0, 0, 2'b00, 2'b00, 32'h0,         3'd0);
        tbl[8]  = mk(2'b11, 1, 0, 32'h0,         1, A1,    1, 2'b10, 2'b00, 32'h0,         3'd0);
        tbl[9]  = mk(2'b11, 1, 0, 32'h0,         1, A1,    1, 2'b10, 2'b00, 32'h0,         3'd1);
        tbl[10] = mk(2'b11, 1, 0, 32'h0,         1, A1,    1, 2'b10, 2'b00, 32'h0,         3'd2);
        tbl[11] = mk(2'b11, 1, 0, 32'h0,         1, A1,    1, 2'b10, 2'b00, 32'h0,         3'd3);
        tbl[12] = mk(2'b11, 1, 0, 32'h0,         0, 32'h0, 0, 2'b00, 2'b00, 32'h0,         3'd4);
        tbl[13] = mk(2'b11, 1, 1, 32'hAAAA_AAAA, 0, 32'h0, 0, 2'b00, 2'b10, 32'hAAAA_AAAA, 3'd4);
        tbl[14] = mk(2'b11, 0, 0, 32'h0,         1, A1,    1, 2'b00, 2'b00, 32'h0,         3'd3);

        do_reset();
        check("reset_err_f", 64'(err_f), 64'h0);
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].req, tbl[i].aok, tbl[i].dok, tbl[i].srd);
            check($sformatf("v%0d_s_req", i),   64'(s_req_f),   64'(tbl[i].exp_sreq));
            check($sformatf("v%0d_s_addr", i),  64'(s_addr_f),  64'(tbl[i].exp_saddr));
            check($sformatf("v%0d_s_wr", i),    64'(s_wr_f),    64'(tbl[i].exp_swr));
            check($sformatf("v%0d_addr_ok", i), 64'(addr_ok_f), 64'(tbl[i].exp_aok));
            check($sformatf("v%0d_data_ok", i), 64'(data_ok_f), 64'(tbl[i].exp_dok));
            check($sformatf("v%0d_rdata", i),   64'(rdata_f),   64'(tbl[i].exp_rd));
            check($sformatf("v%0d_outst", i),   64'(out_f),     64'(tbl[i].exp_out));
            if (i == 1) begin
                check("v1_s_wdata", 64'(s_wdata_f), 64'h0000_0000_B1B1_B1B1);
                check("v1_s_wstrb", 64'(s_wstrb_f), 64'hF);
                check("v1_s_size",  64'(s_size_f),  64'd2);
            end
        end

        // round-robin: continuous requests alternate ch0, ch1, ...
        do_reset();
        drive(2'b00, 0, 0, 32'h0);
        check("rr_idle_s_req", 64'(s_req_r), 64'h0);
        check("rr_idle_outst", 64'(out_r), 64'h0);
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1, 0, 32'h0);
            check($sformatf("rr_g%0d_addr_ok", k), 64'(addr_ok_r), (k % 2) ? 64'h2 : 64'h1);
            check($sformatf("rr_g%0d_s_addr", k),  64'(s_addr_r),  (k % 2) ? 64'(A1) : 64'(A0));
            check($sformatf("rr_g%0d_outst", k),   64'(out_r),     64'(k));
            if (k == 0) begin
                check("rr_g0_s_wdata", 64'(s_wdata_r), 64'h0000_0000_A0A0_A0A0);
                check("rr_g0_s_wstrb", 64'(s_wstrb_r), 64'h1);
                check("rr_g0_s_size",  64'(s_size_r),  64'd0);
                check("rr_g0_s_wr",    64'(s_wr_r),    64'd0);
            end
        end
        drive(2'b11, 1, 0, 32'h0);
        check("rr_full_s_req", 64'(s_req_r), 64'h0);
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 0, 1, 32'hD000_0000 + 32'(k));
            check($sformatf("rr_r%0d_data_ok", k), 64'(data_ok_r), (k % 2) ? 64'h2 : 64'h1);
            check($sformatf("rr_r%0d_rdata", k),   64'(rdata_r),   64'(32'hD000_0000 + 32'(k)));
        end

        // concurrent accept/response on the fixed arbiter, 20 requests across pointer wrap
        do_reset();
        q.delete();
        for (int k = 0; k < 22; k++) begin
            rq = (k < 20) ? ((k % 2) ? 2'b10 : 2'b01) : 2'b00;
            dk = (q.size() > 0);
            drive(rq, 1, dk, 32'hC000_0000 + 32'(k));
            check($sformatf("wr%0d_addr_ok", k), 64'(addr_ok_f), 64'(rq));
            check($sformatf("wr%0d_data_ok", k), 64'(data_ok_f), dk ? ((q[0] == 2'd1) ? 64'h2 : 64'h1) : 64'h0);
            check($sformatf("wr%0d_rdata", k),   64'(rdata_f),   dk ? 64'(32'hC000_0000 + 32'(k)) : 64'h0);
            check($sformatf("wr%0d_outst", k),   64'(out_f),     64'(q.size()));
            if (dk) void'(q.pop_front());
            ch = (rq == 2'b10) ? 2'd1 : 2'd0;
            if (rq != 2'b00) q.push_back(ch);
        end

        // spurious response with empty FIFO
        do_reset();
        drive(2'b00, 0, 1, 32'h5555_5555);
        check("sp_data_ok_f", 64'(data_ok_f), 64'h0);
        check("sp_data_ok_r", 64'(data_ok_r), 64'h0);
        check("sp_rdata_f",   64'(rdata_f),   64'h0);
        drive(2'b00, 0, 0, 32'h0);
        check("sp_err_f", 64'(err_f), 64'h1);
        check("sp_err_r", 64'(err_r), 64'h1);
        drive(2'b01, 1, 0, 32'h0);
        check("sp_err_sticky", 64'(err_f), 64'h1);
        check("sp_accept_ok",  64'(addr_ok_f), 64'h1);
        do_reset();
        drive(2'b00, 0, 0, 32'h0);
        check("sp_err_cleared", 64'(err_f), 64'h0);
        check("sp_outst_cleared", 64'(out_f), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
